// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the MOESIF memory arbiter.
//
// Contents:
//   state_t          - arbiter FSM states (IDLE, ACCESS, RELEASE, LOCKED)
//   INDEX_WIDTH      - index width for the default requester count
//   MAX_REQUESTERS   - largest requester count next_round_robin supports
//   next_round_robin - first set request bit after lastGrant, wrapping
//
// LOCKED is only ever entered when MEMORY_ARBITER_LOCK_EN is defined.
package memory_arbiter_pkg;

  localparam int DEFAULT_NUMBER_OF_CACHES = 4;
  localparam int INDEX_WIDTH              = $clog2(DEFAULT_NUMBER_OF_CACHES);
  localparam int MAX_REQUESTERS           = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  // Searches lastGrant+1, lastGrant+2, ... modulo numRequesters and returns the
  // first requesting index. Walking the offsets from largest to smallest
  // lets the smallest offset overwrite the result, so the nearest
  // requester after lastGrant wins.
  //
  // The loop has a fixed bound so it unrolls into a fixed structure. The
  // caller checks whether any request is set, because the result is 0
  // when there is no request.
  function automatic int next_round_robin(input logic [MAX_REQUESTERS-1:0] request,
                                          input int lastGrant,
                                          input int numRequesters);
    int result;
    int idx;
    result = 0;
    for (int step = MAX_REQUESTERS; step >= 1; step--) begin
      idx = (lastGrant + step) % numRequesters;
      if ((step <= numRequesters) && request[idx[3:0]]) begin
        result = idx;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/memory_arbiter_selector.sv
// round_robin_selector: combinational round-robin pick.
//
// Ports:
//   request   in  NUMBER_OF_REQUESTERS  pending request bits
//   lastGrant in  INDEX_BITS            index served most recently
//   valid     out 1                     at least one request is pending
//   index     out INDEX_BITS            next index to serve
//
// This block is generic. The snoop-bus arbiter can use it too.
// NUMBER_OF_REQUESTERS must not be greater than MAX_REQUESTERS.
module round_robin_selector
  import memory_arbiter_pkg::*;
#(
  parameter int NUMBER_OF_REQUESTERS = 4,
  parameter int INDEX_BITS           = 2
) (
  input  logic [NUMBER_OF_REQUESTERS-1:0] request,
  input  logic [INDEX_BITS-1:0]           lastGrant,
  output logic                            valid,
  output logic [INDEX_BITS-1:0]           index
);

  logic [MAX_REQUESTERS-1:0] requestWide;
  int                        pick;

  assign requestWide = MAX_REQUESTERS'(request);

  always_comb begin
    pick = next_round_robin(requestWide, int'(lastGrant), NUMBER_OF_REQUESTERS);
  end

  assign valid = |request;
  assign index = INDEX_BITS'(pick);

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: lets NUMBER_OF_CACHES cache-side memory interfaces share one
// main-memory port. Requesters are served in round-robin order.
//
// Ports:
//   clock, reset                rising-edge clock; asynchronous reset, active low
//   address/dataOut             per-requester address and write data
//   readEnabled/writeEnabled    per-requester request (request = read | write)
//   dataIn/functionComplete     per-requester read data and completion
//   memory*                     shared memory port
//   grant                       one-hot current owner, 0 while IDLE
//   lock                        (MEMORY_ARBITER_LOCK_EN only) keeps ownership after RELEASE
//   debugState                  current FSM state
//
// Handshake: a requester holds read/write until it sees functionComplete.
// functionComplete then stays at 1 until the requester drops both enables
// (4-phase). If the requester drops its enables before completion, the
// access is aborted and the arbiter goes back to IDLE.
//
// Optional feature: define MEMORY_ARBITER_LOCK_EN to add the lock port and
// the LOCKED state.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH    = 16,
  parameter int DATA_WIDTH       = 16,
  parameter int NUMBER_OF_CACHES = 4
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic [NUMBER_OF_CACHES-1:0][ADDRESS_WIDTH-1:0] address,
  input  logic [NUMBER_OF_CACHES-1:0][DATA_WIDTH-1:0]    dataOut,
  input  logic [NUMBER_OF_CACHES-1:0]                    readEnabled,
  input  logic [NUMBER_OF_CACHES-1:0]                    writeEnabled,
  output logic [NUMBER_OF_CACHES-1:0][DATA_WIDTH-1:0]    dataIn,
  output logic [NUMBER_OF_CACHES-1:0]                    functionComplete,
  output logic [ADDRESS_WIDTH-1:0]                       memoryAddress,
  output logic [DATA_WIDTH-1:0]                          memoryDataOut,
  output logic                                           memoryReadEnabled,
  output logic                                           memoryWriteEnabled,
  input  logic [DATA_WIDTH-1:0]                          memoryDataIn,
  input  logic                                           memoryFunctionComplete,
  output logic [NUMBER_OF_CACHES-1:0]                    grant,
`ifdef MEMORY_ARBITER_LOCK_EN
  input  logic [NUMBER_OF_CACHES-1:0]                    lock,
`endif
  output state_t                                         debugState
);

  localparam int GRANT_INDEX_WIDTH = (NUMBER_OF_CACHES > 1) ? $clog2(NUMBER_OF_CACHES) : 1;

  state_t                         state, nextState;
  logic [GRANT_INDEX_WIDTH-1:0]   grantIndex, nextGrantIndex;
  logic [GRANT_INDEX_WIDTH-1:0]   lastGrant, nextLastGrant;
  logic [DATA_WIDTH-1:0]          heldData;
  logic [NUMBER_OF_CACHES-1:0]    request;
  logic                           grantedRequest;
  logic                           selValid;
  logic [GRANT_INDEX_WIDTH-1:0]   selIndex;

  assign request        = readEnabled | writeEnabled;
  assign grantedRequest = request[grantIndex];
  assign debugState     = state;

  round_robin_selector #(
    .NUMBER_OF_REQUESTERS (NUMBER_OF_CACHES),
    .INDEX_BITS           (GRANT_INDEX_WIDTH)
  ) u_selector (
    .request   (request),
    .lastGrant (lastGrant),
    .valid     (selValid),
    .index     (selIndex)
  );

  // lastGrant starts at the top index, so requester 0 wins first after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grantIndex <= '0;
      lastGrant  <= GRANT_INDEX_WIDTH'(NUMBER_OF_CACHES - 1);
      heldData   <= '0;
    end else begin
      state      <= nextState;
      grantIndex <= nextGrantIndex;
      lastGrant  <= nextLastGrant;
      // Latch the read data at the completion edge. RELEASE keeps showing
      // this value after memory has moved on.
      if ((state == ACCESS) && memoryFunctionComplete) begin
        heldData <= memoryDataIn;
      end
    end
  end

  always_comb begin
    nextState      = state;
    nextGrantIndex = grantIndex;
    nextLastGrant  = lastGrant;
    case (state)
      IDLE: begin
        if (selValid) begin
          nextGrantIndex = selIndex;
          nextState      = ACCESS;
        end
      end
      ACCESS: begin
        if (memoryFunctionComplete) begin
          nextState = RELEASE;
        end else if (!grantedRequest) begin
          // The requester aborted. Its turn still counts as used.
          nextLastGrant = grantIndex;
          nextState     = IDLE;
        end
      end
      RELEASE: begin
        if (!grantedRequest) begin
`ifdef MEMORY_ARBITER_LOCK_EN
          if (lock[grantIndex]) begin
            nextState = LOCKED;
          end else begin
            nextLastGrant = grantIndex;
            nextState     = IDLE;
          end
`else
          nextLastGrant = grantIndex;
          nextState     = IDLE;
`endif
        end
      end
      LOCKED: begin
`ifdef MEMORY_ARBITER_LOCK_EN
        if (!lock[grantIndex]) begin
          nextLastGrant = grantIndex;
          nextState     = IDLE;
        end else if (grantedRequest) begin
          nextState = ACCESS;
        end
`else
        nextState = IDLE;
`endif
      end
      default: nextState = IDLE;
    endcase
  end

  // The outputs are combinational. Because reset forces state to IDLE
  // asynchronously, all outputs go to 0 as soon as reset is asserted.
  always_comb begin
    grant              = '0;
    memoryAddress      = '0;
    memoryDataOut      = '0;
    memoryReadEnabled  = 1'b0;
    memoryWriteEnabled = 1'b0;
    dataIn             = '0;
    functionComplete   = '0;
    case (state)
      ACCESS: begin
        grant[grantIndex]            = 1'b1;
        memoryAddress                = address[grantIndex];
        memoryDataOut                = dataOut[grantIndex];
        // Read and write both set is a requester fault. The arbiter forwards it unchanged.
        memoryReadEnabled            = readEnabled[grantIndex];
        memoryWriteEnabled           = writeEnabled[grantIndex];
        dataIn[grantIndex]           = memoryDataIn;
        functionComplete[grantIndex] = memoryFunctionComplete;
      end
      RELEASE: begin
        grant[grantIndex]            = 1'b1;
        dataIn[grantIndex]           = heldData;
        functionComplete[grantIndex] = 1'b1;
      end
      LOCKED: begin
        grant[grantIndex] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares one memory port among NUMBER_OF_CACHES cache-side memory interfaces in the MOESIF cache system.
- Each requester uses the codebase's memory handshake: address, dataOut, readEnabled, writeEnabled in; dataIn, functionComplete out.
- The arbiter grants one requester at a time in round-robin order, forwards its transaction to the shared memory, and routes the completion back.
- Sits between the per-cache memory interfaces and the single main-memory model.

Parameters:
- ADDRESS_WIDTH, 16, address bits per access.
- DATA_WIDTH, 16, data bits per access.
- NUMBER_OF_CACHES, 4, number of requesters (>=2).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- address  in  NUMBER_OF_CACHES x ADDRESS_WIDTH  per-requester address.
- dataOut  in  NUMBER_OF_CACHES x DATA_WIDTH  per-requester write data.
- readEnabled  in  NUMBER_OF_CACHES  per-requester read request.
- writeEnabled  in  NUMBER_OF_CACHES  per-requester write request.
- dataIn  out  NUMBER_OF_CACHES x DATA_WIDTH  per-requester read data.
- functionComplete  out  NUMBER_OF_CACHES  per-requester completion.
- memoryAddress  out  ADDRESS_WIDTH  shared memory address.
- memoryDataOut  out  DATA_WIDTH  shared memory write data.
- memoryReadEnabled  out  1  shared memory read.
- memoryWriteEnabled  out  1  shared memory write.
- memoryDataIn  in  DATA_WIDTH  shared memory read data.
- memoryFunctionComplete  in  1  shared memory completion.
- grant  out  NUMBER_OF_CACHES  one-hot current owner, for debug and monitors.

Behaviour:
- Request vector: request[i] = readEnabled[i] | writeEnabled[i].
- Reset (asynchronous assert, takes effect immediately, including mid-transaction):
  - state = IDLE; grantIndex = 0; lastGrant = NUMBER_OF_CACHES-1, so requester 0 wins first.
  - All memory* outputs, grant, every functionComplete and every dataIn are 0.
- State IDLE:
  - Memory enables are 0; grant is 0.
  - If any request bit is set, pick the first set bit searching from lastGrant+1, wrapping modulo NUMBER_OF_CACHES.
  - Register the pick as grantIndex and go to ACCESS.
  - Latency: the request is sampled at edge N; memory enables are visible after edge N.
- State ACCESS:
  - grant[grantIndex]=1.
  - Memory outputs are a combinational mux of the granted requester's address, dataOut, readEnabled and writeEnabled.
  - Read and write are forwarded unchanged. Both set together is a requester protocol violation; it is passed through, not corrected.
  - dataIn[grantIndex] = memoryDataIn and functionComplete[grantIndex] = memoryFunctionComplete, both combinational. All other requesters see 0 on both.
  - When memoryFunctionComplete=1 at an edge, go to RELEASE.
  - If the granted requester drops both enables before completion (abort), set lastGrant=grantIndex and go to IDLE.
- State RELEASE:
  - Memory enables are forced to 0.
  - functionComplete[grantIndex] is held at 1. dataIn[grantIndex] holds the value latched at the completion edge.
  - When the granted requester shows request=0, set lastGrant=grantIndex and go to IDLE. This completes a 4-phase handshake.
- Fairness: a requester that holds its request continuously is served within NUMBER_OF_CACHES-1 other grants.
- Back-to-back: IDLE always lasts at least one cycle between grants.
- Simultaneous requests in IDLE are resolved purely by round-robin; there is no fixed priority.

Optional Feature:
- Macro: MEMORY_ARBITER_LOCK_EN.
- With the macro defined:
  - Adds input port lock (NUMBER_OF_CACHES bits).
  - If lock[grantIndex]=1 when leaving RELEASE, go to state LOCKED instead of IDLE, with grant held.
  - In LOCKED, only a request from grantIndex is accepted; it returns to ACCESS on the next edge. Other requesters wait.
  - If lock[grantIndex] drops, go to IDLE with lastGrant=grantIndex.
  - Intended for atomic read-modify-write and bus-lock sequences.
- Without the macro: no lock port, no LOCKED state, pure round-robin.

Decomposition:
- Package memory_arbiter_pkg:
  - State enum (IDLE, ACCESS, RELEASE, LOCKED).
  - Function next_round_robin(request, lastGrant) returning an index.
  - Localparam for the index width, $clog2(NUMBER_OF_CACHES).
- One natural sub-module: round_robin_selector. It is combinational, takes the request vector and lastGrant, and outputs a valid bit plus the selected index. It is reusable for the snoop-bus arbiter.

Test Plan (NUMBER_OF_CACHES=4, widths 16):
- Single read: cache 2 reads 0x1234, memory returns 0xBEEF after 3 cycles. Expected: memoryAddress=0x1234, dataIn[2]=0xBEEF, functionComplete[2] held until readEnabled[2] drops, then grant=0.
- Round-robin: all four request in the same cycle from reset. Expected grant order 0,1,2,3; the next request from 0 after that is served before a re-request from 1.
- Write passthrough: cache 1 writes 0x00AA to 0x0040. Expected: memoryWriteEnabled=1, memoryDataOut=0x00AA; no other requester sees functionComplete.
- Reset mid-ACCESS: reset pulled low while cache 3 is granted. Expected: all outputs 0 immediately; after release, cache 0's pending request wins first.
- Abort: cache 0 drops readEnabled before memoryFunctionComplete. Expected: memory enables 0 on the same cycle, state IDLE, and the next grant goes to cache 1 if it is requesting.
- LOCK (macro defined): cache 2 holds lock across two accesses while cache 0 requests. Expected: both cache-2 accesses complete before cache 0 is granted.
